// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - default fixed-point formats shared by the multiplier and accumulator path
package fp_pkg;

    localparam int FP_NB_IN   = 20;
    localparam int FP_NBF_IN  = 17;
    localparam int FP_NB_OUT  = 12;
    localparam int FP_NBF_OUT = 11;
    localparam int FP_N_ACC   = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/fp_round_sat.sv
// rtl/fp_round_sat.sv - round (FP_FRAME_ACC_ROUND_EN) or floor, then saturate S(NB_ACC,NBF_IN) to S(NB_OUT,NBF_OUT)
module fp_round_sat
    import fp_pkg::*;
#(
    parameter int NB_ACC  = 24,
    parameter int NBF_IN  = FP_NBF_IN,
    parameter int NB_OUT  = FP_NB_OUT,
    parameter int NBF_OUT = FP_NBF_OUT
) (
    input  logic [NB_ACC-1:0] i_sum,
    output logic [NB_OUT-1:0] o_data,
    output logic              o_ovf
);

    localparam int D = NBF_IN - NBF_OUT;
    localparam logic [NB_OUT-1:0] SAT_MAX = {1'b0, {(NB_OUT-1){1'b1}}};
    localparam logic [NB_OUT-1:0] SAT_MIN = {1'b1, {(NB_OUT-1){1'b0}}};

`ifdef FP_FRAME_ACC_ROUND_EN
    // One guard bit so adding the half-LSB to the most positive sum cannot wrap.
    localparam int W = NB_ACC + 1 - D;
    localparam logic [NB_ACC:0] HALF = (NB_ACC+1)'(2 ** D / 2);
    logic signed [NB_ACC:0] wide;
`else
    localparam int W = NB_ACC - D;
`endif

    logic signed [W-1:0] q;

    always_comb begin
`ifdef FP_FRAME_ACC_ROUND_EN
        wide = {i_sum[NB_ACC-1], i_sum} + HALF;
        q    = W'(wide >>> D);
`else
        q    = W'($signed(i_sum) >>> D);
`endif
    end

    generate
        if (W > NB_OUT) begin : g_sat
            logic [W-NB_OUT:0] hi;
            always_comb begin
                hi     = q[W-1:NB_OUT-1];
                o_ovf  = !((&hi) || !(|hi));
                o_data = q[NB_OUT-1:0];
                if (o_ovf) begin
                    o_data = q[W-1] ? SAT_MIN : SAT_MAX;
                end
            end
        end else begin : g_ext
            always_comb begin
                o_ovf  = 1'b0;
                o_data = NB_OUT'(q);
            end
        end
    endgenerate

endmodule

// File: rtl/fp_frame_acc.sv
// rtl/fp_frame_acc.sv - frame accumulator of signed products with round/saturate output; FP_FRAME_ACC_ROUND_EN selects round-half-up
module fp_frame_acc
    import fp_pkg::*;
#(
    parameter int NB_IN   = FP_NB_IN,
    parameter int NBF_IN  = FP_NBF_IN,
    parameter int N_ACC   = FP_N_ACC,
    parameter int NB_OUT  = FP_NB_OUT,
    parameter int NBF_OUT = FP_NBF_OUT
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_valid,
    input  logic [NB_IN-1:0]                 i_data,
    input  logic                             i_clear,
    output logic                             o_in_ready,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [NB_OUT-1:0]                o_data,
    output logic                             o_ovf,
    output logic [NB_IN+clog2(N_ACC)-1:0]    o_acc_fr
);

    localparam int NB_ACC = NB_IN + clog2(N_ACC);
    localparam int CNT_W  = clog2(N_ACC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ACC - 1);

    logic [NB_ACC-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [NB_OUT-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;
    logic [NB_ACC-1:0] fr_q, fr_d;

    logic [NB_ACC-1:0] sum;
    logic [NB_OUT-1:0] rs_data;
    logic              rs_ovf;
    logic              last_beat;
    logic              in_ready;
    logic              beat;

    // Stall only a frame-completing beat that would overwrite an unaccepted result.
    always_comb begin
        last_beat = (cnt_q == LAST);
        in_ready  = !i_clear && !(valid_q && !i_ready && last_beat);
        beat      = i_valid && in_ready;
        sum       = acc_q + {{(NB_ACC-NB_IN){i_data[NB_IN-1]}}, i_data};
    end

    fp_round_sat #(
        .NB_ACC  (NB_ACC),
        .NBF_IN  (NBF_IN),
        .NB_OUT  (NB_OUT),
        .NBF_OUT (NBF_OUT)
    ) u_round_sat (
        .i_sum  (sum),
        .o_data (rs_data),
        .o_ovf  (rs_ovf)
    );

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q && !i_ready;
        data_d  = data_q;
        ovf_d   = ovf_q;
        fr_d    = fr_q;
        if (i_clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (beat) begin
            if (last_beat) begin
                acc_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b1;
                data_d  = rs_data;
                ovf_d   = rs_ovf;
                fr_d    = sum;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            fr_q    <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            fr_q    <= fr_d;
        end
    end

    assign o_in_ready = in_ready;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_ovf      = ovf_q;
    assign o_acc_fr   = fr_q;

endmodule

// File: tb/tb_fp_frame_acc.sv
// tb/tb_fp_frame_acc.sv - self-checking bench for fp_frame_acc (FP_FRAME_ACC_ROUND_EN aware)
module tb_fp_frame_acc;

    localparam int N_ACC = 16;
    localparam int D     = 6;
    localparam int NV    = 9;

`ifdef FP_FRAME_ACC_ROUND_EN
    localparam logic [11:0] RND_POS = 12'h001;
    localparam logic [11:0] RND_NEG = 12'h000;
`else
    localparam logic [11:0] RND_POS = 12'h000;
    localparam logic [11:0] RND_NEG = 12'hFFF;
`endif

    typedef struct packed {
        logic [19:0] first;
        logic [19:0] rest;
        logic [11:0] d;
        logic        ovf;
        logic [23:0] fr;
    } vec_t;

    typedef struct packed {
        logic [11:0] d;
        logic        ovf;
        logic [23:0] fr;
    } res_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [19:0] i_data;
    logic        i_clear;
    logic        i_ready;
    logic        o_in_ready;
    logic        o_valid;
    logic [11:0] o_data;
    logic        o_ovf;
    logic [23:0] o_acc_fr;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    fp_frame_acc dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_clear    (i_clear),
        .o_in_ready (o_in_ready),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_ovf      (o_ovf),
        .o_acc_fr   (o_acc_fr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Reference result from plain integer arithmetic on the exact frame sum.
    function automatic res_t expect_of(input longint s);
        res_t   r;
        longint v;
`ifdef FP_FRAME_ACC_ROUND_EN
        v = (s + 2 ** (D - 1)) >>> D;
`else
        v = s >>> D;
`endif
        r.ovf = (v > 2047) || (v < -2048);
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        r.d  = v[11:0];
        r.fr = s[23:0];
        return r;
    endfunction

    task automatic run_frame(input string tag, input logic [19:0] first, input logic [19:0] rest,
                             input logic [11:0] ed, input logic eovf, input logic [23:0] efr);
        i_ready = 1'b1;
        i_clear = 1'b0;
        for (int b = 0; b < N_ACC; b++) begin
            i_valid = 1'b1;
            i_data  = (b == 0) ? first : rest;
            #1;
            chk({tag, " in_ready"}, o_in_ready, 1);
            tick();
            if (b == N_ACC - 2) chk({tag, " early_valid"}, o_valid, 0);
        end
        i_valid = 1'b0;
        i_data  = '0;
        chk({tag, " valid"}, o_valid, 1);
        chk({tag, " data"}, o_data, ed);
        chk({tag, " ovf"}, o_ovf, eovf);
        chk({tag, " acc_fr"}, o_acc_fr, efr);
        tick();
        chk({tag, " drained"}, o_valid, 0);
    endtask

    vec_t        vecs[NV];
    res_t        q[$];
    int          cnt;
    longint      fsum;
    logic        rv, rr, rc, exp_rdy;
    logic [19:0] rd;
    logic [31:0] tmp;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{20'h01000, 20'h01000, 12'h400, 1'b0, 24'h010000};
        vecs[1] = '{20'h20000, 20'h20000, 12'h7FF, 1'b1, 24'h200000};
        vecs[2] = '{20'hE0000, 20'hE0000, 12'h800, 1'b1, 24'hE00000};
        vecs[3] = '{20'h00020, 20'h00000, RND_POS, 1'b0, 24'h000020};
        vecs[4] = '{20'hFFFE0, 20'h00000, RND_NEG, 1'b0, 24'hFFFFE0};
        vecs[5] = '{20'h7FFFF, 20'h7FFFF, 12'h7FF, 1'b1, 24'h7FFFF0};
        vecs[6] = '{20'h80000, 20'h80000, 12'h800, 1'b1, 24'h800000};
        vecs[7] = '{20'h01FFC, 20'h01FFC, 12'h7FF, 1'b0, 24'h01FFC0};
        vecs[8] = '{20'h1F000, 20'h00000, 12'h7C0, 1'b0, 24'h01F000};

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset o_valid", o_valid, 0);
        chk("reset o_data", o_data, 0);
        chk("reset o_ovf", o_ovf, 0);
        chk("reset o_acc_fr", o_acc_fr, 0);
        i_rst_n = 1'b1;
        #1;
        chk("reset in_ready", o_in_ready, 1);
        tick();

        for (int i = 0; i < NV; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].first, vecs[i].rest, vecs[i].d, vecs[i].ovf, vecs[i].fr);
        end

        // Backpressure: frame 1 parks in the output, frame 2 stalls on its last beat.
        i_ready = 1'b0;
        for (int b = 0; b < N_ACC; b++) begin
            i_valid = 1'b1;
            i_data  = 20'h01000;
            tick();
        end
        chk("bp f1 valid", o_valid, 1);
        chk("bp f1 data", o_data, 12'h400);
        for (int b = 0; b < N_ACC; b++) begin
            i_valid = 1'b1;
            i_data  = 20'h00800;
            #1;
            chk($sformatf("bp in_ready beat%0d", b), o_in_ready, (b != N_ACC - 1));
            if (b != N_ACC - 1) tick();
        end
        tick();
        #1;
        chk("bp stalled in_ready", o_in_ready, 0);
        chk("bp stalled valid", o_valid, 1);
        chk("bp held data", o_data, 12'h400);
        chk("bp held acc_fr", o_acc_fr, 24'h010000);
        i_ready = 1'b1;
        #1;
        chk("bp release in_ready", o_in_ready, 1);
        tick();
        chk("bp f2 valid", o_valid, 1);
        chk("bp f2 data", o_data, 12'h200);
        chk("bp f2 acc_fr", o_acc_fr, 24'h008000);
        i_valid = 1'b0;
        tick();
        chk("bp drained", o_valid, 0);

        // Back-to-back frames at full rate.
        i_ready = 1'b1;
        for (int k = 0; k < 3 * N_ACC; k++) begin
            i_valid = 1'b1;
            i_data  = 20'h01000;
            #1;
            chk("b2b in_ready", o_in_ready, 1);
            tick();
            chk($sformatf("b2b valid k%0d", k), o_valid, ((k + 1) % N_ACC == 0));
            if ((k + 1) % N_ACC == 0) chk("b2b data", o_data, 12'h400);
        end
        i_valid = 1'b0;
        tick();

        // Clear after a partial frame of large values.
        for (int b = 0; b < 5; b++) begin
            i_valid = 1'b1;
            i_data  = 20'h20000;
            tick();
        end
        i_clear = 1'b1;
        #1;
        chk("clear in_ready", o_in_ready, 0);
        tick();
        i_clear = 1'b0;
        run_frame("after_clear", 20'h01000, 20'h01000, 12'h400, 1'b0, 24'h010000);

        // Asynchronous reset mid-frame with a pending result.
        i_ready = 1'b0;
        for (int b = 0; b < N_ACC + 5; b++) begin
            i_valid = 1'b1;
            i_data  = 20'h01000;
            tick();
        end
        i_valid = 1'b0;
        chk("pre_rst valid", o_valid, 1);
        i_rst_n = 1'b0;
        #1;
        chk("rst valid", o_valid, 0);
        chk("rst data", o_data, 0);
        chk("rst acc_fr", o_acc_fr, 0);
        tick();
        i_rst_n = 1'b1;
        run_frame("after_rst", 20'h00800, 20'h00800, 12'h200, 1'b0, 24'h008000);

        // Randomised traffic against the frame-level reference model.
        cnt  = 0;
        fsum = 0;
        for (int c = 0; c < 3000; c++) begin
            rv  = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 3) != 0);
            rc  = ($urandom_range(0, 40) == 0);
            tmp = $urandom;
            rd  = $urandom_range(0, 1) ? tmp[19:0] : {{7{tmp[12]}}, tmp[12:0]};
            i_valid = rv;
            i_ready = rr;
            i_clear = rc;
            i_data  = rd;
            #1;
            exp_rdy = !rc && !(q.size() > 0 && !rr && cnt == N_ACC - 1);
            chk("rnd in_ready", o_in_ready, exp_rdy);
            chk("rnd valid", o_valid, (q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd data", o_data, q[0].d);
                chk("rnd ovf", o_ovf, q[0].ovf);
                chk("rnd acc_fr", o_acc_fr, q[0].fr);
            end
            tick();
            if (q.size() > 0 && rr) void'(q.pop_front());
            if (rc) begin
                cnt  = 0;
                fsum = 0;
            end else if (rv && exp_rdy) begin
                fsum += longint'($signed(rd));
                cnt++;
                if (cnt == N_ACC) begin
                    q.push_back(expect_of(fsum));
                    cnt  = 0;
                    fsum = 0;
                end
            end
        end
        i_valid = 1'b0;
        i_clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_frame_acc.md
# fp_frame_acc

Frame accumulator placed directly downstream of the fixed-point multiplier. It consumes full-resolution signed products and sums a fixed number of them per frame. It then rounds and saturates each frame sum to the output format and presents the result on a valid/ready interface. Typical use is the MAC tail of an FIR/correlator built from the multiplier.

## Interface
- NB_IN, 20, total bits of input product (multiplier full-resolution width)
- NBF_IN, 17, fractional bits of input product
- N_ACC, 16, products per frame (≥2)
- NB_OUT, 12, total bits of rounded/saturated result
- NBF_OUT, 11, fractional bits of result (NBF_OUT ≤ NBF_IN)
- Derived: NB_ACC = NB_IN + clog2(N_ACC); D = NBF_IN − NBF_OUT (dropped bits)
- Clock and reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input product valid
- i_data  in  NB_IN  signed product S(NB_IN,NBF_IN)
- i_clear  in  1  synchronous frame abort, clears accumulator and count
- o_in_ready  out  1  block can accept i_data this cycle
- o_valid  out  1  result held in output register
- i_ready  in  1  downstream accepts result
- o_data  out  NB_OUT  signed result S(NB_OUT,NBF_OUT)
- o_ovf  out  1  result was saturated
- o_acc_fr  out  NB_ACC  full-resolution frame sum, S(NB_ACC,NBF_IN)

## Operation
- An input beat is accepted when i_valid && o_in_ready. The accumulator adds the sign-extended i_data, and the count increments.
- On the N_ACC-th beat, sum = acc + i_data is formed at full resolution. It is rounded, saturated and loaded into the output register. The accumulator and count return to 0, with no bubble.
- Saturation limits: max = 0 followed by NB_OUT−1 ones; min = 1 followed by NB_OUT−1 zeros. o_ovf=1 only when a clamp occurred.
- Output register holds o_data/o_ovf/o_acc_fr stable while o_valid && !i_ready.
- o_in_ready = !i_clear && !(o_valid && !i_ready && count==N_ACC−1). A beat is stalled only when it would complete a frame into a full, unaccepted output.
- Simultaneous output accept and frame completion: the register reloads and o_valid stays 1.
- i_clear zeroes acc and count; o_in_ready is low that cycle and no beat is consumed. The output register is unaffected.
- Reset mid-frame: the partial sum is discarded and any pending output is dropped.
- Reset values: o_valid=0, o_data=0, o_ovf=0, o_acc_fr=0, acc=0, count=0. o_in_ready=1 after reset deassertion.

## Timing
- Latency: result appears on o_valid one cycle after the final beat of the frame is accepted.
- Throughput: one product per cycle sustained while downstream holds i_ready=1.
- The adder, round and saturate logic form a single combinational stage into the output register. The accumulator register is the only feedback path.

## Configuration
- FP_FRAME_ACC_ROUND_EN defined: round half up. Add 2^(D−1) to the sum at width NB_ACC+1, then drop D LSBs, then saturate.
- Not defined: truncate by dropping D LSBs (floor), then saturate. The sum is not widened.

## Structure
- Package fp_pkg holds the default format constants shared with the multiplier (NB_IN/NBF_IN, NB_OUT/NBF_OUT) and a clog2 function.
- Sub-module fp_round_sat: combinational round (macro-controlled) plus saturation from S(NB_ACC,NBF_IN) to S(NB_OUT,NBF_OUT), with an ovf flag. It is reusable by the multiplier path.

## Test plan
- Nominal sum: defaults, 16 beats of 0x01000 (0.03125), i_ready=1 → o_data=0x400 (0.5), o_ovf=0, o_acc_fr=0x010000, o_valid one cycle after beat 16.
- Positive and negative saturation: 16×0x20000 (+1.0) → o_data=0x7FF, o_ovf=1. 16×0xE0000 (−1.0) → o_data=0x800, o_ovf=1.
- Rounding: one beat 0x00020, 15 beats 0 → 0x001 with ROUND_EN, 0x000 without. One beat 0xFFFE0, rest 0 → 0x000 with ROUND_EN, 0xFFF without.
- Backpressure: i_ready=0 while a full second frame streams in → o_in_ready drops only on its 16th beat. Raising i_ready delivers frame 1, then frame 2 on the next cycle with no data loss.
- Back-to-back: continuous i_valid with i_ready=1 for 3 frames → o_valid pulses every 16 cycles and o_in_ready stays 1 throughout.
- Clear/reset: i_clear after 5 beats, then 16×0x01000 → 0x400. Assert i_rst_n=0 mid-frame with o_valid=1 → o_valid=0 immediately and the next full frame gives the correct result.
